q1_inv_table: RTL and testbench
===============================

// Module: q1_inv_table
// PURPOSE
//  Inverse Twofish q1 byte permutation for the decrypt-side key schedule / h() path.
//  After reset, an INIT sequencer walks the forward q1 permutation over all 256 inputs and
//  writes the 256x8 inverse table (tbl[q1(i)] <= i). It then serves lookups on a
//  valid/ready stream. MODE also allows forward q1 through the same stream.
// PARAMETERS
//  NONE        -    table depth is fixed at 256, data width is fixed at 8
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  asynchronous, active-high reset
//  rebuild     in   1  pulse: restart INIT; ignored while already in INIT
//  in_valid    in   1  request valid
//  in_ready    out  1  request accepted when in_valid && in_ready
//  in_mode     in   1  0 = inverse q1 (table), 1 = forward q1 (combinational, registered)
//  in_data     in   8  byte to translate
//  out_valid   out  1  result valid
//  out_ready   in   1  downstream ready
//  out_data    out  8  translated byte
//  init_done   out  1  table complete
//  chk_err     out  1  sticky self-check mismatch (SELF_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  Forward q1(X): {a0,b0}=X (a0 = high nibble)
//   - a1 = a0^b0
//   - b1 = a0^ROR4(b0,1)^((a0<<3)&4'hF)
//   - a2 = T0[a1], b2 = T1[b1]
//   - repeat the mix: a3 = a2^b2, b3 = a2^ROR4(b2,1)^((a2<<3)&4'hF)
//   - a4 = T2[a3], b4 = T3[b3]
//   - q1 = {b4,a4}
//  Tables, hex, index 0..F:
//   T0 = 2 8 B D F 7 6 E 3 1 9 4 0 A C 5
//   T1 = 1 E 2 B 4 C 3 7 6 D A 5 F 9 0 8
//   T2 = 4 C 7 5 1 6 9 A 0 E D 8 2 B 3 F
//   T3 = B 9 5 1 C 3 D E 6 4 7 F 2 0 8 A
//  FSM:
//   - states: INIT, SERVE. Reset state is INIT, with cnt=0.
//   - INIT: each cycle write tbl[q1(cnt)] <= cnt, then cnt++. After the cnt=255 write go to SERVE.
//     Exactly 256 cycles.
//   - SERVE: on rebuild=1 go to INIT with cnt=0, and drop init_done on the next edge.
//  Reset values: out_valid=0, out_data=8'h00, init_done=0, chk_err=0, cnt=0.
//   Table contents are not reset; they are rewritten by INIT.
//  Handshake:
//   - in_ready = (state==SERVE) && !rebuild && (!out_valid || out_ready).
//     in_ready is 0 throughout INIT.
//   - Latency 1: an accepted request updates out_data/out_valid on the next edge.
//   - Full throughput: 1 result per cycle while out_ready=1.
//   - out_valid holds and out_data is stable while out_valid && !out_ready.
//   - out_valid falls only when out_ready=1 and no new accept in the same cycle.
//  Boundaries:
//   - rebuild while out_valid=1: the pending result is kept until consumed; no new accepts until INIT ends.
//   - rebuild asserted in the same cycle as in_valid: no accept (in_ready=0).
//   - rst mid-INIT or mid-transfer: immediate return to reset values; INIT restarts from cnt=0.
//   - in_data widths are exact; cnt wraps only via the state exit, never 255->0 inside INIT.
// CONFIGURATION
//  SELF_CHECK_EN defined:
//   - each inverse result r is checked: q1(r) must equal the registered request byte.
//   - on a mismatch, chk_err is set on the same edge out_valid rises; it is sticky until rst.
//   - forward mode is not checked.
//  SELF_CHECK_EN undefined: no check logic; chk_err tied 0.
// TESTING
//  1. rst pulse -> init_done=0 and in_ready=0 for 256 clks, then init_done=1.
//     Outputs are 0 during reset.
//  2. inverse 8'h75 -> out_data 8'h00; inverse 8'hF3 -> 8'h01; forward 8'h00 -> 8'h75.
//     Each result appears 1 clk after accept.
//  3. Stream all 256 bytes in inverse mode back-to-back with out_ready=1.
//     -> 1 result/clk, inv(q1(i))=i for all i, results are a permutation of 0..255.
//  4. Hold out_ready=0 with a result pending, in_valid=1.
//     -> in_ready=0, out_data stable; release -> next result follows with no loss or duplication.
//  5. rebuild pulse in SERVE with a pending result.
//     -> pending result drains, init_done=0 for 256 clks, then lookups are correct again.
//  6. rst asserted at cnt=100 in INIT -> full 256-cycle INIT after release.
//     With SELF_CHECK_EN, full sweep -> chk_err stays 0.

Source files
------------

// File: rtl/q1_inv_table.sv
// rtl/q1_inv_table.sv - inverse/forward Twofish q1 byte translator with self-built 256x8 inverse table
// Optional self-check of inverse results is enabled by defining SELF_CHECK_EN.
module q1_inv_table (
  input  logic       clk,
  input  logic       rst,
  input  logic       rebuild,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_mode,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       init_done,
  output logic       chk_err
);

  // Nibble tables packed with entry 0 in the least significant nibble.
  localparam logic [63:0] T0 = 64'h5CA04913E67FDB82;
  localparam logic [63:0] T1 = 64'h809F5AD673C4B2E1;
  localparam logic [63:0] T2 = 64'hF3B28DE0A96157C4;
  localparam logic [63:0] T3 = 64'hA802F746ED3C159B;

  typedef enum logic {ST_INIT, ST_SERVE} state_t;

  function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] i);
    return t[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] q1(input logic [7:0] x);
    logic [3:0] a1, b1, a2, b2, a3, b3;
    a1 = x[7:4] ^ x[3:0];
    b1 = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
    a2 = nib(T0, a1);
    b2 = nib(T1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    return {nib(T3, b3), nib(T2, a3)};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       init_done_q, init_done_d;

  logic [7:0] tbl [256];
  logic [7:0] tbl_rd;
  logic [7:0] wr_addr;
  logic [7:0] result;
  logic       accept;

  assign in_ready  = (state_q == ST_SERVE) && !rebuild && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign tbl_rd    = tbl[in_data];
  assign result    = in_mode ? q1(in_data) : tbl_rd;
  assign wr_addr   = q1(cnt_q);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          state_d = ST_SERVE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        if (rebuild) begin
          state_d = ST_INIT;
          cnt_d   = 8'd0;
        end
      end
    endcase
    init_done_d = (state_d == ST_SERVE);
    // A pending result survives a rebuild; it only leaves when consumed.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Table storage is not reset; INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      tbl[wr_addr] <= cnt_q;
    end
  end

`ifdef SELF_CHECK_EN
  logic chk_err_q, chk_err_d;

  assign chk_err_d = chk_err_q | (accept && !in_mode && (q1(tbl_rd) != in_data));
  assign chk_err   = chk_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_q1_inv_table.sv
// tb/tb_q1_inv_table.sv - scoreboard bench for q1_inv_table
module tb_q1_inv_table;

  logic       clk = 1'b0;
  logic       rst;
  logic       rebuild;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       init_done;
  logic       chk_err;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] sb [$];
  logic [7:0] inv_m [256];

  localparam logic [3:0] TT0 [16] = '{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5};
  localparam logic [3:0] TT1 [16] = '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8};
  localparam logic [3:0] TT2 [16] = '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF};
  localparam logic [3:0] TT3 [16] = '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA};

  q1_inv_table dut (
    .clk(clk), .rst(rst), .rebuild(rebuild),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .init_done(init_done), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ror1(input logic [3:0] v);
    return (v >> 1) | ((v << 3) & 4'hF);
  endfunction

  function automatic logic [7:0] q1m(input logic [7:0] x);
    logic [3:0] a, b, am, bm;
    a  = x[7:4];
    b  = x[3:0];
    am = a ^ b;
    bm = a ^ ror1(b) ^ ((a << 3) & 4'hF);
    a  = TT0[am];
    b  = TT1[bm];
    am = a ^ b;
    bm = a ^ ror1(b) ^ ((a << 3) & 4'hF);
    return {TT3[bm], TT2[am]};
  endfunction

  // Called just after a falling edge: score current outputs, drive inputs, record the handshake.
  task automatic set_in(input logic v, input logic m, input logic [7:0] d, input logic ordy, input logic rb);
    n_run++;
    if (out_valid !== (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL sb_valid: out_valid=%b expected %b", out_valid, sb.size() != 0);
    end
    if (sb.size() != 0) begin
      n_run++;
      if (out_data !== sb[0]) begin
        n_fail++;
        $display("FAIL sb_data: out_data=%h expected %h", out_data, sb[0]);
      end
    end
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    out_ready = ordy;
    rebuild   = rb;
    #1;
    if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
    if (in_valid && in_ready) sb.push_back(m ? q1m(d) : inv_m[d]);
  endtask

  task automatic wait_init(input string tag);
    for (int k = 0; k < 256; k++) begin
      set_in(1'b1, 1'b0, k[7:0], 1'b1, 1'b0);
      n_run++;
      if (init_done !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy: k=%0d init_done=%b in_ready=%b expected 0 0", tag, k, init_done, in_ready);
      end
      @(negedge clk);
    end
    n_run++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: init_done=%b expected 1", tag, init_done);
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
    end
    n_run++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: left=%0d out_valid=%b expected 0 0", tag, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rebuild = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || init_done !== 1'b0 || chk_err !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: v=%b d=%h done=%b err=%b rdy=%b expected 0 00 0 0 0",
               out_valid, out_data, init_done, chk_err, in_ready);
    end
    rst = 1'b0;
    wait_init("reset");
  endtask

  task automatic test_basic();
    set_in(1'b1, 1'b0, 8'h75, 1'b1, 1'b0);
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL inv_75: v=%b d=%h expected 1 00", out_valid, out_data);
    end
    set_in(1'b1, 1'b0, 8'hF3, 1'b1, 1'b0);
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      n_fail++;
      $display("FAIL inv_F3: v=%b d=%h expected 1 01", out_valid, out_data);
    end
    set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h75) begin
      n_fail++;
      $display("FAIL fwd_00: v=%b d=%h expected 1 75", out_valid, out_data);
    end
    drain("basic");
  endtask

  task automatic test_back_to_back();
    int seen [256];
    int uniq;
    foreach (seen[i]) seen[i] = 0;
    for (int i = 0; i <= 256; i++) begin
      if (i > 0 && out_valid === 1'b1) seen[out_data]++;
      if (i < 256) begin
        set_in(1'b1, 1'b0, q1m(i[7:0]), 1'b1, 1'b0);
        n_run++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready: i=%0d in_ready=%b expected 1", i, in_ready);
        end
      end else begin
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      @(negedge clk);
    end
    uniq = 0;
    foreach (seen[i]) if (seen[i] == 1) uniq++;
    n_run++;
    if (uniq != 256) begin
      n_fail++;
      $display("FAIL b2b_perm: distinct results=%0d expected 256", uniq);
    end
    drain("b2b");
    n_run++;
    if (chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_chk: chk_err=%b expected 0", chk_err);
    end
  endtask

  task automatic test_backpressure();
    set_in(1'b1, 1'b0, 8'h75, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b0, 8'hF3, 1'b0, 1'b0);
      n_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h00) begin
        n_fail++;
        $display("FAIL stall: k=%0d rdy=%b v=%b d=%h expected 0 1 00", k, in_ready, out_valid, out_data);
      end
      @(negedge clk);
    end
    set_in(1'b1, 1'b0, 8'hF3, 1'b1, 1'b0);
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      n_fail++;
      $display("FAIL release_next: v=%b d=%h expected 1 01", out_valid, out_data);
    end
    drain("stall");
  endtask

  task automatic test_rebuild();
    set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    set_in(1'b1, 1'b0, 8'h75, 1'b0, 1'b1);
    n_run++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rebuild_ready: in_ready=%b expected 0", in_ready);
    end
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h75 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rebuild_hold: v=%b d=%h done=%b expected 1 75 0", out_valid, out_data, init_done);
    end
    wait_init("rebuild");
    set_in(1'b1, 1'b0, 8'hF3, 1'b1, 1'b0);
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      n_fail++;
      $display("FAIL rebuild_lookup: v=%b d=%h expected 1 01", out_valid, out_data);
    end
    drain("rebuild");
  endtask

  task automatic test_rst_mid_init();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || init_done !== 1'b0 || chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midinit_rst: v=%b d=%h done=%b err=%b expected 0 00 0 0", out_valid, out_data, init_done, chk_err);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_init("midinit");
    for (int k = 0; k < 40; k++) begin
      set_in(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
    end
    drain("random");
    n_run++;
    if (chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL final_chk: chk_err=%b expected 0", chk_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inv_m[q1m(i[7:0])] = i[7:0];
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_rebuild();
    test_rst_mid_init();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
